// File: rtl/rx_frame_ctl_if.sv
// rtl/rx_frame_ctl_if.sv - serial-receiver and buffer-write bus of the receive frame controller
interface rx_frame_ctl_if #(
    parameter int ADDR_W = 8
);
    logic              ser_bus_idle;
    logic [7:0]        ser_data;
    logic [15:0]       ser_crc_data;
    logic              ser_data_clk;
    logic              ser_wait_bus_idle;
    logic [7:0]        wr_byte;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_clk;
    logic [7:0]        wr_flags;
    logic              switch;

    // receiver / buffer side: supplies bytes, observes buffer writes
    modport master (
        output ser_bus_idle, ser_data, ser_crc_data, ser_data_clk,
        input  ser_wait_bus_idle, wr_byte, wr_addr, wr_clk, wr_flags, switch
    );

    // frame controller side
    modport slave (
        input  ser_bus_idle, ser_data, ser_crc_data, ser_data_clk,
        output ser_wait_bus_idle, wr_byte, wr_addr, wr_clk, wr_flags, switch
    );
endinterface

// File: rtl/rx_frame_ctl.sv
// rtl/rx_frame_ctl.sv - receive frame controller: address filter, length/CRC check, ping-pong commit
module rx_frame_ctl #(
    parameter int ADDR_W = 8,
    parameter int NFILT  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         filter,
    input  logic [8*NFILT-1:0] filter_m,
    input  logic [NFILT-1:0]   filter_m_en,
    input  logic               user_crc,
    input  logic               not_drop,
    input  logic               abort,
    output logic               error,
    output logic               err_len,
    rx_frame_ctl_if.slave      bus
);
    localparam int              CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // 10 bits holds any length byte plus header/trailer and any byte counter value
    localparam logic [9:0]      DEPTH10 = 10'(1 << ADDR_W);

    typedef enum logic [1:0] {
        RECV    = 2'd0,
        CLEANUP = 2'd1
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  byte_cnt, byte_cnt_nxt;
    logic [7:0]        data_len, data_len_nxt;
    logic              drop, drop_nxt;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
    logic [7:0]        wr_flags_q, wr_flags_nxt;
    logic              wr_clk_q, wr_clk_nxt;
    logic              switch_q, switch_nxt;
    logic              wait_q, wait_nxt;
    logic              error_q, error_nxt;
    logic              err_len_q, err_len_nxt;

    logic              mc_hit;
    logic [9:0]        cnt10;
    logic [9:0]        len_need;
    logic [9:0]        last_idx;

    function automatic logic [7:0] sat8(input logic [9:0] v);
        return (v > 10'd255) ? 8'hff : v[7:0];
    endfunction

    assign cnt10    = 10'(byte_cnt);
    assign len_need = {2'b00, bus.ser_data} + 10'd5;
    assign last_idx = {2'b00, data_len} + 10'd4;

    // destination byte matches any enabled multicast slot
    always_comb begin
        mc_hit = 1'b0;
        for (int i = 0; i < NFILT; i++) begin
            if (filter_m_en[i] && (filter_m[8*i +: 8] == bus.ser_data)) begin
                mc_hit = 1'b1;
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RECV;
        end else begin
            state <= state_nxt;
        end
    end

    // next state, frame bookkeeping and output pulses
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        data_len_nxt = data_len;
        drop_nxt     = drop;
        wr_addr_nxt  = wr_addr_q;
        wr_flags_nxt = wr_flags_q;
        wr_clk_nxt   = 1'b0;
        switch_nxt   = 1'b0;
        wait_nxt     = 1'b0;
        error_nxt    = 1'b0;
        err_len_nxt  = 1'b0;

        case (state)
            RECV: begin
                if (bus.ser_bus_idle) begin
                    // idle mid-frame: truncated; a lone byte is just noise
                    if (byte_cnt != '0) begin
                        if ((cnt10 >= 10'd2) && !drop) begin
                            error_nxt = 1'b1;
                            if (not_drop) begin
                                wr_flags_nxt = sat8(cnt10);
                                switch_nxt   = 1'b1;
                            end
                        end
                        state_nxt = CLEANUP;
                    end
                end else if (bus.ser_data_clk) begin
                    wr_addr_nxt = byte_cnt[ADDR_W-1:0];
                    wr_clk_nxt  = (cnt10 < DEPTH10);
                    if (byte_cnt != CNT_MAX) begin
                        byte_cnt_nxt = byte_cnt + 1'b1;
                    end
                    if (cnt10 == 10'd0) begin
                        // our own transmissions echoed back are not received
                        if ((filter != 8'hff) && (bus.ser_data == filter)) begin
                            drop_nxt = 1'b1;
                        end
                    end else if (cnt10 == 10'd1) begin
                        if (!((filter == 8'hff) || (bus.ser_data == filter) ||
                              (bus.ser_data == 8'hff) || mc_hit)) begin
                            drop_nxt = 1'b1;
                        end
                    end else if (cnt10 == 10'd2) begin
                        data_len_nxt = bus.ser_data;
                        if (len_need > DEPTH10) begin
                            err_len_nxt = 1'b1;
                            error_nxt   = !drop;
                            state_nxt   = CLEANUP;
                        end
                    end else if (cnt10 == last_idx) begin
                        if (!drop) begin
                            if ((bus.ser_crc_data == 16'h0000) || user_crc) begin
                                wr_flags_nxt = 8'h00;
                                switch_nxt   = 1'b1;
                            end else begin
                                error_nxt = 1'b1;
                                if (not_drop) begin
                                    wr_flags_nxt = sat8(cnt10 + 10'd1);
                                    switch_nxt   = 1'b1;
                                end
                            end
                        end
                        state_nxt = CLEANUP;
                    end
                end
            end
            CLEANUP: begin
                wait_nxt     = 1'b1;
                byte_cnt_nxt = '0;
                data_len_nxt = 8'h00;
                drop_nxt     = 1'b0;
                state_nxt    = RECV;
            end
            default: begin
                state_nxt = CLEANUP;
            end
        endcase

        // abort overrides any commit or error decided this cycle
        if (abort) begin
            error_nxt   = 1'b0;
            err_len_nxt = 1'b0;
            switch_nxt  = 1'b0;
            state_nxt   = CLEANUP;
        end
    end

    // frame bookkeeping and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt   <= '0;
            data_len   <= 8'h00;
            drop       <= 1'b0;
            wr_addr_q  <= '0;
            wr_flags_q <= 8'h00;
            wr_clk_q   <= 1'b0;
            switch_q   <= 1'b0;
            wait_q     <= 1'b0;
            error_q    <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            byte_cnt   <= byte_cnt_nxt;
            data_len   <= data_len_nxt;
            drop       <= drop_nxt;
            wr_addr_q  <= wr_addr_nxt;
            wr_flags_q <= wr_flags_nxt;
            wr_clk_q   <= wr_clk_nxt;
            switch_q   <= switch_nxt;
            wait_q     <= wait_nxt;
            error_q    <= error_nxt;
            err_len_q  <= err_len_nxt;
        end
    end

    assign bus.wr_byte           = bus.ser_data;
    assign bus.wr_addr           = wr_addr_q;
    assign bus.wr_flags          = wr_flags_q;
    assign bus.wr_clk            = wr_clk_q;
    assign bus.switch            = switch_q;
    assign bus.ser_wait_bus_idle = wait_q;
    assign error                 = error_q;
    assign err_len               = err_len_q;
endmodule

// File: tb/tb_rx_frame_ctl.sv
// tb/tb_rx_frame_ctl.sv - self-checking bench for rx_frame_ctl (ADDR_W=8 and ADDR_W=6 instances)
module tb_rx_frame_ctl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [7:0]  filter;
    logic [15:0] filter_m;
    logic [1:0]  filter_m_en;
    logic        user_crc, not_drop, abort;
    logic        err_a, errlen_a, err_b, errlen_b;
    logic        ser_bus_idle, ser_data_clk;
    logic [7:0]  ser_data;
    logic [15:0] ser_crc;

    rx_frame_ctl_if #(.ADDR_W(8)) bus_a ();
    rx_frame_ctl_if #(.ADDR_W(6)) bus_b ();

    assign bus_a.ser_bus_idle = ser_bus_idle;
    assign bus_a.ser_data     = ser_data;
    assign bus_a.ser_crc_data = ser_crc;
    assign bus_a.ser_data_clk = ser_data_clk;
    assign bus_b.ser_bus_idle = ser_bus_idle;
    assign bus_b.ser_data     = ser_data;
    assign bus_b.ser_crc_data = ser_crc;
    assign bus_b.ser_data_clk = ser_data_clk;

    rx_frame_ctl #(.ADDR_W(8), .NFILT(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .filter(filter), .filter_m(filter_m),
        .filter_m_en(filter_m_en), .user_crc(user_crc), .not_drop(not_drop),
        .abort(abort), .error(err_a), .err_len(errlen_a), .bus(bus_a)
    );

    rx_frame_ctl #(.ADDR_W(6), .NFILT(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .filter(filter), .filter_m(filter_m),
        .filter_m_en(filter_m_en), .user_crc(user_crc), .not_drop(not_drop),
        .abort(abort), .error(err_b), .err_len(errlen_b), .bus(bus_b)
    );

    typedef struct {
        int nwr;
        int addr_ok;
        int sw;
        int flags;
        int err;
        int errlen;
        int wt;
    } obs_t;

    typedef struct {
        logic [63:0] bytes;
        int          n;
        logic        crc_bad;
        logic [7:0]  filt;
        logic [15:0] fm;
        logic [1:0]  fm_en;
        logic        ucrc;
        logic        nd;
        int          e_sw;
        int          e_flags;
        int          e_err;
        int          e_errlen;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // running event totals per instance, sampled mid-cycle
    int wr_a = 0, sw_a = 0, er_a = 0, el_a = 0, wt_a = 0, fl_a = 0;
    int wr_b = 0, sw_b = 0, er_b = 0, el_b = 0, wt_b = 0, fl_b = 0;
    int addr_a [0:511];
    int addr_b [0:511];

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus_a.wr_clk) begin
                addr_a[wr_a % 512] <= int'(bus_a.wr_addr);
                wr_a <= wr_a + 1;
            end
            if (bus_a.switch) begin
                sw_a <= sw_a + 1;
                fl_a <= int'(bus_a.wr_flags);
            end
            if (err_a)                   er_a <= er_a + 1;
            if (errlen_a)                el_a <= el_a + 1;
            if (bus_a.ser_wait_bus_idle) wt_a <= wt_a + 1;
            if (bus_b.wr_clk) begin
                addr_b[wr_b % 512] <= int'(bus_b.wr_addr);
                wr_b <= wr_b + 1;
            end
            if (bus_b.switch) begin
                sw_b <= sw_b + 1;
                fl_b <= int'(bus_b.wr_flags);
            end
            if (err_b)                   er_b <= er_b + 1;
            if (errlen_b)                el_b <= el_b + 1;
            if (bus_b.ser_wait_bus_idle) wt_b <= wt_b + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic obs_t snap(input int which);
        obs_t s;
        if (which == 0) s = '{wr_a, 1, sw_a, fl_a, er_a, el_a, wt_a};
        else            s = '{wr_b, 1, sw_b, fl_b, er_b, el_b, wt_b};
        return s;
    endfunction

    function automatic int addrs_in_order(input int which, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            if (which == 0 && addr_a[(base + k) % 512] != k) return 0;
            if (which == 1 && addr_b[(base + k) % 512] != k) return 0;
        end
        return 1;
    endfunction

    function automatic obs_t diff(input int which, input obs_t s0, input obs_t s1);
        obs_t d;
        d.nwr     = s1.nwr - s0.nwr;
        d.addr_ok = addrs_in_order(which, s0.nwr, d.nwr);
        d.sw      = s1.sw - s0.sw;
        d.flags   = s1.flags;
        d.err     = s1.err - s0.err;
        d.errlen  = s1.errlen - s0.errlen;
        d.wt      = s1.wt - s0.wt;
        return d;
    endfunction

    // frame-level reference: what one received frame must produce on a buffer of 'depth' bytes
    function automatic obs_t model(input logic [7:0] fb[$], input int n, input logic crc_bad,
                                   input int depth);
        obs_t r;
        bit   drop;
        bit   acc;
        int   total;
        r = '{0, 1, 0, 0, 0, 0, 0};
        if (n == 0) return r;
        drop = (filter != 8'hff) && (fb[0] == filter);
        if (n >= 2) begin
            acc = (filter == 8'hff) || (fb[1] == filter) || (fb[1] == 8'hff) ||
                  (filter_m_en[0] && fb[1] == filter_m[7:0]) ||
                  (filter_m_en[1] && fb[1] == filter_m[15:8]);
            if (!acc) drop = 1'b1;
        end
        r.wt = 1;
        if (n >= 3 && int'(fb[2]) + 5 > depth) begin
            r.nwr    = 3;
            r.errlen = 1;
            r.err    = drop ? 0 : 1;
            return r;
        end
        total = (n >= 3) ? int'(fb[2]) + 5 : n + 1;
        if (n >= total) begin
            r.nwr = total;
            if (!drop) begin
                if (!crc_bad || user_crc) begin
                    r.sw = 1;
                end else begin
                    r.err = 1;
                    if (not_drop) begin
                        r.sw    = 1;
                        r.flags = (total > 255) ? 255 : total;
                    end
                end
            end
        end else begin
            r.nwr = n;
            if (n >= 2 && !drop) begin
                r.err = 1;
                if (not_drop) begin
                    r.sw    = 1;
                    r.flags = n;
                end
            end
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic [15:0] crc);
        ser_data     = b;
        ser_crc      = crc;
        ser_data_clk = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_gap();
        ser_data_clk = 1'b0;
        ser_bus_idle = 1'b1;
        repeat (2) @(negedge clk);
        ser_bus_idle = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] fb[$], input int n, input logic crc_bad,
                             output obs_t oa, output obs_t ob);
        obs_t sa0, sb0;
        logic [15:0] c;
        sa0 = snap(0);
        sb0 = snap(1);
        for (int k = 0; k < n; k++) begin
            if (k == n - 1) c = crc_bad ? 16'($urandom_range(1, 65535)) : 16'h0000;
            else            c = 16'($urandom);
            send_byte(fb[k], c);
        end
        idle_gap();
        oa = diff(0, sa0, snap(0));
        ob = diff(1, sb0, snap(1));
    endtask

    task automatic compare_obs(input string tag, input obs_t got, input obs_t exp);
        chk({tag, " writes"},    got.nwr,     exp.nwr);
        chk({tag, " addr_seq"},  got.addr_ok, 1);
        chk({tag, " switch"},    got.sw,      exp.sw);
        chk({tag, " error"},     got.err,     exp.err);
        chk({tag, " err_len"},   got.errlen,  exp.errlen);
        chk({tag, " wait_idle"}, got.wt,      exp.wt);
        if (exp.sw != 0) chk({tag, " wr_flags"}, got.flags, exp.flags);
    endtask

    vec_t        vt [14];
    logic [7:0]  fb[$];
    logic [7:0]  f1[$];
    obs_t        oa, ob;
    int          full, n, len, pick;
    logic        crc_bad;
    logic [7:0]  src, dst;

    initial begin
        reset_n = 1'b0; filter = 8'h03; filter_m = 16'h0000; filter_m_en = 2'b00;
        user_crc = 1'b0; not_drop = 1'b0; abort = 1'b0;
        ser_bus_idle = 1'b0; ser_data_clk = 1'b0; ser_data = 8'h00; ser_crc = 16'h0000;
        repeat (3) @(negedge clk);

        chk("reset error",    int'(err_a),                   0);
        chk("reset err_len",  int'(errlen_a),                0);
        chk("reset wr_clk",   int'(bus_a.wr_clk),            0);
        chk("reset switch",   int'(bus_a.switch),            0);
        chk("reset wr_addr",  int'(bus_a.wr_addr),           0);
        chk("reset wr_flags", int'(bus_a.wr_flags),          0);
        chk("reset wait",     int'(bus_a.ser_wait_bus_idle), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // good frame: one write per byte, commit one cycle after the last byte
        f1 = '{8'h05, 8'h03, 8'h02, 8'hAA, 8'hBB, 8'hC0, 8'hC1};
        for (int k = 0; k < 7; k++) begin
            ser_data = f1[k]; ser_data_clk = 1'b1; ser_crc = (k == 6) ? 16'h0000 : 16'h5A5A;
            #1 chk("wr_byte passthrough", int'(bus_a.wr_byte), int'(f1[k]));
            @(negedge clk);
            chk("t1 wr_clk", int'(bus_a.wr_clk), 1);
            chk("t1 wr_addr", int'(bus_a.wr_addr), k);
            chk("t1 switch timing", int'(bus_a.switch), (k == 6) ? 1 : 0);
        end
        chk("t1 wr_flags", int'(bus_a.wr_flags), 0);
        ser_data_clk = 1'b0;
        @(negedge clk);
        chk("t1 wait after commit", int'(bus_a.ser_wait_bus_idle), 1);
        chk("t1 switch one cycle", int'(bus_a.switch), 0);
        idle_gap();

        // bad CRC with not_drop: error and switch together, flags = length
        not_drop = 1'b1;
        for (int k = 0; k < 6; k++) send_byte(f1[k], 16'h0000);
        send_byte(f1[6], 16'hBEEF);
        chk("t3 error", int'(err_a), 1);
        chk("t3 switch", int'(bus_a.switch), 1);
        chk("t3 wr_flags", int'(bus_a.wr_flags), 7);
        idle_gap();
        not_drop = 1'b0;

        // length field exceeds a 64-byte buffer
        send_byte(8'h05, 16'h0000);
        send_byte(8'h03, 16'h0000);
        send_byte(8'd60, 16'h0000);
        chk("t4 err_len", int'(errlen_b), 1);
        chk("t4 error", int'(err_b), 1);
        chk("t4 switch", int'(bus_b.switch), 0);
        ser_data_clk = 1'b0;
        @(negedge clk);
        chk("t4 wait", int'(bus_b.ser_wait_bus_idle), 1);
        idle_gap();

        // abort coinciding with the last byte of a good frame
        for (int k = 0; k < 6; k++) send_byte(f1[k], 16'h0000);
        abort = 1'b1;
        send_byte(f1[6], 16'h0000);
        chk("t6 switch", int'(bus_a.switch), 0);
        chk("t6 error", int'(err_a), 0);
        abort = 1'b0;
        ser_data_clk = 1'b0;
        @(negedge clk);
        chk("t6 wait", int'(bus_a.ser_wait_bus_idle), 1);
        idle_gap();
        run_frame(f1, 7, 1'b0, oa, ob);
        chk("t6 next switch", oa.sw, 1);
        chk("t6 next flags", oa.flags, 0);
        chk("t6 next error", oa.err, 0);

        // table of whole frames with fixed expectations for the 256-byte instance
        //             bytes (byte0 in LSB)       n cb filt   fm        en   uc   nd   sw fl er el
        vt[0]  = '{64'h00C1C0BBAA020305, 7, 1'b0, 8'h03, 16'h0000, 2'b00, 1'b0, 1'b0, 1, 0, 0, 0};
        vt[1]  = '{64'h000000C1C000E005, 5, 1'b0, 8'h03, 16'hE000, 2'b10, 1'b0, 1'b0, 1, 0, 0, 0};
        vt[2]  = '{64'h000000C1C000E005, 5, 1'b0, 8'h03, 16'hE000, 2'b00, 1'b0, 1'b0, 0, 0, 0, 0};
        vt[3]  = '{64'h00C1C0BBAA020305, 7, 1'b1, 8'h03, 16'h0000, 2'b00, 1'b0, 1'b1, 1, 7, 1, 0};
        vt[4]  = '{64'h00C1C0BBAA020305, 7, 1'b1, 8'h03, 16'h0000, 2'b00, 1'b0, 1'b0, 0, 0, 1, 0};
        vt[5]  = '{64'h00C1C0BBAA020305, 4, 1'b0, 8'h03, 16'h0000, 2'b00, 1'b0, 1'b1, 1, 4, 1, 0};
        vt[6]  = '{64'h00C1C0BBAA020305, 1, 1'b0, 8'h03, 16'h0000, 2'b00, 1'b0, 1'b1, 0, 0, 0, 0};
        vt[7]  = '{64'h00C1C0BBAA020305, 7, 1'b1, 8'h03, 16'h0000, 2'b00, 1'b1, 1'b0, 1, 0, 0, 0};
        vt[8]  = '{64'h00C1C0BBAA020303, 7, 1'b1, 8'h03, 16'h0000, 2'b00, 1'b0, 1'b1, 0, 0, 0, 0};
        vt[9]  = '{64'h00C1C0BBAA027703, 7, 1'b0, 8'hFF, 16'h0000, 2'b00, 1'b0, 1'b0, 1, 0, 0, 0};
        vt[10] = '{64'h00C1C0BBAA02FF05, 7, 1'b0, 8'h03, 16'h0000, 2'b00, 1'b0, 1'b0, 1, 0, 0, 0};
        vt[11] = '{64'h0000000000FC0305, 3, 1'b0, 8'h03, 16'h0000, 2'b00, 1'b0, 1'b1, 0, 0, 1, 1};
        vt[12] = '{64'h00C1C0BBAA020905, 4, 1'b0, 8'h03, 16'h0000, 2'b00, 1'b0, 1'b1, 0, 0, 0, 0};
        vt[13] = '{64'h000000C1C0000305, 5, 1'b1, 8'h03, 16'h0000, 2'b00, 1'b0, 1'b1, 1, 5, 1, 0};
        for (int i = 0; i < 14; i++) begin
            filter = vt[i].filt; filter_m = vt[i].fm; filter_m_en = vt[i].fm_en;
            user_crc = vt[i].ucrc; not_drop = vt[i].nd;
            fb.delete();
            for (int k = 0; k < 8; k++) fb.push_back(vt[i].bytes[8*k +: 8]);
            run_frame(fb, vt[i].n, vt[i].crc_bad, oa, ob);
            chk($sformatf("vec%0d switch", i),  oa.sw,     vt[i].e_sw);
            chk($sformatf("vec%0d error", i),   oa.err,    vt[i].e_err);
            chk($sformatf("vec%0d err_len", i), oa.errlen, vt[i].e_errlen);
            if (vt[i].e_sw != 0) chk($sformatf("vec%0d wr_flags", i), oa.flags, vt[i].e_flags);
            compare_obs($sformatf("vec%0d depth64", i), ob, model(fb, vt[i].n, vt[i].crc_bad, 64));
        end

        // randomized frames against the frame-level model, both buffer depths
        for (int f = 0; f < 80; f++) begin
            pick = $urandom_range(0, 3);
            filter      = (pick == 0) ? 8'h03 : (pick == 1) ? 8'hFF : 8'($urandom);
            filter_m    = 16'($urandom);
            filter_m_en = 2'($urandom_range(0, 3));
            user_crc    = ($urandom_range(0, 7) == 0);
            not_drop    = 1'($urandom_range(0, 1));
            src = ($urandom_range(0, 5) == 0) ? filter : 8'($urandom);
            pick = $urandom_range(0, 4);
            dst = (pick == 0) ? filter : (pick == 1) ? 8'hFF :
                  (pick == 2) ? filter_m[7:0] : (pick == 3) ? filter_m[15:8] : 8'($urandom);
            len  = ($urandom_range(0, 9) == 0) ? $urandom_range(252, 255) : $urandom_range(0, 59);
            full = (len >= 252) ? 3 : len + 5;
            fb.delete();
            fb.push_back(src);
            fb.push_back(dst);
            fb.push_back(8'(len));
            for (int k = 3; k < full; k++) fb.push_back(8'($urandom));
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, full) : full;
            crc_bad = ($urandom_range(0, 2) == 0);
            run_frame(fb, n, crc_bad, oa, ob);
            compare_obs($sformatf("rnd%0d depth256", f), oa, model(fb, n, crc_bad, 256));
            compare_obs($sformatf("rnd%0d depth64", f),  ob, model(fb, n, crc_bad, 64));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
